// File: rtl/key_stream_encoder.sv
// Keyboard edge detector feeding a character FIFO: each fresh single key press is queued as
// its ASCII code, and an etx press ends the stream until reset.
module key_stream_encoder #(
  parameter int DEPTH = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [127:0]             Keys,
  input  logic                     CharReady,
  output logic [6:0]               CharOut,
  output logic                     CharValid,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Eot,
  output logic                     Overflow,
  output logic                     MultiKey
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [6:0]    ETX        = 7'h03;

  typedef enum logic {RUN, DONE} state_t;

  state_t         state, state_next;
  logic [127:0]   keys_p0, keys_p1, new_keys;
  logic [6:0]     mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;
  logic [6:0]     code;
  logic           multi, onehot, full, push_req, push, pop;

  function automatic logic [6:0] key_code(input logic [127:0] v);
    logic [6:0] idx;
    idx = 7'd0;
    for (int i = 1; i < 128; i++)
      if (v[i]) idx = 7'(i);
    return idx;
  endfunction

  // Stage p0/p1: sampled key lines and their previous sample for rising-edge detection
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      keys_p0 <= '0;
      keys_p1 <= '0;
    end else begin
      keys_p0 <= Keys;
      keys_p1 <= keys_p0;
    end
  end

  always_comb begin
    new_keys    = keys_p0 & ~keys_p1;
    new_keys[0] = 1'b0;
    // Clearing the lowest set bit leaves something only when two or more bits rose.
    multi       = |(new_keys & (new_keys - 128'd1));
    onehot      = (|new_keys) && !multi;
    code        = key_code(new_keys);
    full        = (count == FULL_COUNT);
    pop         = (count != '0) && CharReady;
    push_req    = (state == RUN) && onehot;
    push        = push_req && (!full || pop);
    state_next  = state;
    if (push && code == ETX)
      state_next = DONE;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) state <= RUN;
    else      state <= state_next;
  end

  // Stage p2: FIFO bookkeeping and sticky flags
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      Overflow <= 1'b0;
      MultiKey <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push)
        Overflow <= 1'b1;
      if (state == RUN && multi)
        MultiKey <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wptr] <= code;
  end

  always_comb begin
    CharValid = (count != '0);
    CharOut   = CharValid ? mem[rptr] : 7'd0;
    Count     = count;
    Eot       = (state == DONE) && (count == '0);
  end

endmodule

// File: tb/tb_key_stream_encoder.sv
// Randomised and directed bench for key_stream_encoder; a press-event model feeds a scoreboard
// that a negedge monitor drains whenever the encoder hands over a character.
`timescale 1ns/1ps
module tb_key_stream_encoder;
  localparam int DEPTH = 16;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [127:0] Keys;
  logic         CharReady;
  logic [6:0]   CharOut;
  logic         CharValid;
  logic [$clog2(DEPTH):0] Count;
  logic         Eot, Overflow, MultiKey;

  always #50 Clk = ~Clk;

  key_stream_encoder #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .Keys(Keys), .CharReady(CharReady),
    .CharOut(CharOut), .CharValid(CharValid), .Count(Count),
    .Eot(Eot), .Overflow(Overflow), .MultiKey(MultiKey)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a press is a 0->1 transition between consecutive samples of Keys;
  // it is acted on one edge later, against the queue occupancy after that edge's pop.
  logic [127:0] m_prev = '0, m_pend = '0;
  int           m_count = 0;
  bit           m_ovf = 0, m_multi = 0, m_done = 0, started = 0;
  logic [6:0]   sbq[$];

  always @(posedge Clk) begin : model
    int n, c;
    if (!Rst) begin
      m_prev = '0; m_pend = '0; m_count = 0;
      m_ovf = 0; m_multi = 0; m_done = 0;
      sbq.delete();
      started = 1;
    end else begin
      if (m_count > 0 && CharReady) m_count--;
      if (!m_done) begin
        n = 0; c = 0;
        for (int b = 1; b < 128; b++)
          if (m_pend[b]) begin n++; c = b; end
        if (n == 1) begin
          if (m_count < DEPTH) begin
            m_count++;
            sbq.push_back(7'(c));
            if (c == 3) m_done = 1;
          end else m_ovf = 1;
        end else if (n >= 2) m_multi = 1;
      end
      m_pend = Keys & ~m_prev;
      m_prev = Keys;
    end
  end

  always @(negedge Clk) begin
    if (started) begin
      check("count", 32'(Count), m_count);
      check("char_valid", 32'(CharValid), 32'(m_count != 0));
      check("overflow", 32'(Overflow), 32'(m_ovf));
      check("multi_key", 32'(MultiKey), 32'(m_multi));
      check("eot", 32'(Eot), 32'(m_done && m_count == 0));
      if (CharValid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL char_unexpected actual=%0h required=none", CharOut);
        end else begin
          check("char_out", 32'(CharOut), 32'(sbq[0]));
          if (CharReady && Rst) void'(sbq.pop_front());
        end
      end else begin
        check("char_out_empty", 32'(CharOut), 0);
      end
    end
  end

  function automatic logic [127:0] key(input int c);
    logic [127:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic step(input logic [127:0] k, input logic r);
    Keys = k;
    CharReady = r;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) step('0, r);
  endtask

  task automatic press_str(input string s, input logic r);
    for (int i = 0; i < s.len(); i++) step(key(int'(s[i])), r);
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    step('0, 1'b0);
    Rst = 1'b1;
  endtask

  initial begin
    logic [127:0] k, prev;
    logic         rdy_bias;
    Rst = 1'b0; Keys = '0; CharReady = 1'b0;
    step('0, 1'b0);
    step('0, 1'b0);
    Rst = 1'b1;

    // single short press with the assembler ready
    step(key(108), 1'b1);
    idle(4, 1'b1);
    check("single_drained", 32'(Count), 0);

    // stream with a held key, then drain in order
    do_reset();
    press_str("label ssr\n", 1'b0);
    idle(3, 1'b0);
    check("stream_count", 32'(Count), 9);
    idle(12, 1'b1);
    check("stream_drained", 32'(Count), 0);

    // two keys rising together
    do_reset();
    step(key(97) | key(98), 1'b0);
    idle(2, 1'b0);
    check("multikey_flag", 32'(MultiKey), 1);
    check("multikey_count", 32'(Count), 0);
    step(key(99), 1'b0);
    idle(2, 1'b0);
    check("after_multi_count", 32'(Count), 1);
    idle(3, 1'b1);

    // overflow, push at full with a simultaneous pop, etx dropped at full
    do_reset();
    for (int i = 0; i < 17; i++) step(key(65 + i), 1'b0);
    idle(2, 1'b0);
    check("full_count", 32'(Count), 16);
    check("full_overflow", 32'(Overflow), 1);
    step(key(122), 1'b0);
    step('0, 1'b1);
    step('0, 1'b0);
    check("full_pushpop_count", 32'(Count), 16);
    step(key(3), 1'b0);
    idle(2, 1'b0);
    check("etx_dropped_count", 32'(Count), 16);
    check("etx_dropped_eot", 32'(Eot), 0);
    idle(20, 1'b1);
    step(key(121), 1'b1);
    idle(4, 1'b1);

    // end of text
    do_reset();
    press_str("ret", 1'b0);
    step(key(3), 1'b0);
    step(key(120), 1'b0);
    idle(3, 1'b0);
    check("etx_count", 32'(Count), 4);
    idle(8, 1'b1);
    check("eot_set", 32'(Eot), 1);
    press_str("abc", 1'b1);
    idle(3, 1'b1);
    check("eot_held", 32'(Eot), 1);
    check("done_count", 32'(Count), 0);

    // reset mid-stream with a key held through release
    do_reset();
    press_str("world", 1'b0);
    idle(2, 1'b0);
    check("mid_count", 32'(Count), 5);
    Rst = 1'b0;
    step(key(113), 1'b0);
    Rst = 1'b1;
    check("mid_reset_count", 32'(Count), 0);
    check("mid_reset_valid", 32'(CharValid), 0);
    repeat (4) step(key(113), 1'b0);
    idle(2, 1'b0);
    check("held_after_reset", 32'(Count), 1);
    idle(3, 1'b1);

    // randomised traffic
    do_reset();
    prev = '0;
    rdy_bias = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 60 == 0) rdy_bias = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: k = '0;
        4, 5:       k = key($urandom_range(32, 126));
        6:          k = prev;
        7:          k = key($urandom_range(1, 127)) | key($urandom_range(1, 127));
        8:          k = key(0) | (($urandom_range(0, 1) == 1) ? key($urandom_range(1, 127)) : '0);
        default:    k = ($urandom_range(0, 7) == 0) ? key(3) : key($urandom_range(1, 127));
      endcase
      Rst = ($urandom_range(0, 49) != 0);
      step(k, rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0));
      prev = k;
    end
    Rst = 1'b1;
    idle(40, 1'b1);
    check("scoreboard_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
